// File: rtl/srt_div_pkg.sv
// Shared types for the radix-2 SRT divider: FSM state encoding and quotient digit codes.
package srt_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGN,
        S_NORM,
        S_ITER,
        S_CORR,
        S_DONE
    } state_t;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b10;

endpackage

// File: rtl/srt_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module srt_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_lzc
);

    always_comb begin
        o_lzc = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_lzc = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/srt_div_seq.sv
// Sequential radix-2 SRT divider, one quotient digit per clock, valid/ready on both sides.
// Define SRT_DIV_SIGNED_EN for two's-complement operands (adds a SIGN state).
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// SIGN   | operands replaced by their magnitudes (signed build only)
// NORM   | divisor normalised by its leading-zero count
// ITER   | WIDTH digit iterations on the partial remainder P
// CORR   | quotient assembled, negative remainder corrected, result registered
// DONE   | result presented until out_ready
module srt_div_seq
    import srt_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     r_p;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_qpos;
    logic [WIDTH-1:0]   r_qneg;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dbz;

    logic [CNT_W-1:0]   w_k;
    logic [2*WIDTH:0]   w_pa_norm;
    logic [2:0]         w_top3;
    logic [1:0]         w_digit;
    logic [WIDTH:0]     w_p_shift;
    logic [WIDTH:0]     w_add_op;
    logic [WIDTH:0]     w_b_ext;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH:0]     w_p_fix;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quot_out;
    logic [WIDTH-1:0]   w_rem_out;

    srt_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
        .i_data (r_b),
        .o_lzc  (w_k)
    );

    assign w_pa_norm = {{(WIDTH+1){1'b0}}, r_a} << w_k;
    assign w_top3    = r_p[WIDTH:WIDTH-2];
    assign w_p_shift = {r_p[WIDTH-1:0], r_a[WIDTH-1]};

    always_comb begin
        w_digit = DIG_POS;
        if (w_top3 == 3'b000 || w_top3 == 3'b111) w_digit = DIG_ZERO;
        else if (r_p[WIDTH])                        w_digit = DIG_NEG;
    end

    // Single adder/subtractor shared by the iterations and the final correction.
    assign w_sub    = (r_state == S_ITER) && (w_digit == DIG_POS);
    assign w_add_op = (r_state == S_ITER) ? w_p_shift : r_p;
    assign w_b_ext  = {1'b0, r_b};
    assign w_sum    = w_add_op + (w_sub ? ~w_b_ext : w_b_ext) + {{WIDTH{1'b0}}, w_sub};

    assign w_q_fix   = (r_qpos - r_qneg) - {{(WIDTH-1){1'b0}}, r_p[WIDTH]};
    assign w_p_fix   = r_p[WIDTH] ? w_sum : r_p;
    assign w_rem_mag = w_p_fix[WIDTH-1:0] >> r_k;

`ifdef SRT_DIV_SIGNED_EN
    logic r_q_sign;
    logic r_r_sign;
    assign w_quot_out = r_q_sign ? -w_q_fix : w_q_fix;
    assign w_rem_out  = r_r_sign ? -w_rem_mag : w_rem_mag;
`else
    assign w_quot_out = w_q_fix;
    assign w_rem_out  = w_rem_mag;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) w_state_nx = S_DONE;
`ifdef SRT_DIV_SIGNED_EN
                    else               w_state_nx = S_SIGN;
`else
                    else               w_state_nx = S_NORM;
`endif
                end
            end
            S_SIGN: w_state_nx = S_NORM;
            S_NORM: w_state_nx = S_ITER;
            S_ITER: if (r_cnt == '0) w_state_nx = S_CORR;
            S_CORR: w_state_nx = S_DONE;
            S_DONE: if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_p    <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
            r_qpos <= '0;
            r_qneg <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
`ifdef SRT_DIV_SIGNED_EN
            r_q_sign <= 1'b0;
            r_r_sign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= dividend;
                        r_b <= divisor;
`ifdef SRT_DIV_SIGNED_EN
                        r_q_sign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_r_sign <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_SIGN: begin
                    r_a <= r_a[WIDTH-1] ? -r_a : r_a;
                    r_b <= r_b[WIDTH-1] ? -r_b : r_b;
                end
                S_NORM: begin
                    r_k    <= w_k;
                    r_b    <= r_b << w_k;
                    r_p    <= w_pa_norm[2*WIDTH:WIDTH];
                    r_a    <= w_pa_norm[WIDTH-1:0];
                    r_cnt  <= CNT_W'(WIDTH - 1);
                    r_qpos <= '0;
                    r_qneg <= '0;
                end
                S_ITER: begin
                    r_a    <= {r_a[WIDTH-2:0], 1'b0};
                    r_p    <= (w_digit == DIG_ZERO) ? w_p_shift : w_sum;
                    r_qpos <= {r_qpos[WIDTH-2:0], w_digit == DIG_POS};
                    r_qneg <= {r_qneg[WIDTH-2:0], w_digit == DIG_NEG};
                    r_cnt  <= r_cnt - 1'b1;
                end
                S_CORR: begin
                    r_quot <= w_quot_out;
                    r_rem  <= w_rem_out;
                    r_dbz  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
